// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - RISC-V MEM pipeline stage: data-memory handshake, branch resolve, MEM/WB register
//
// Purpose:
//   Issues loads/stores from the EX/MEM register over a req/ready handshake
//   that may insert wait states. Stalls upstream while an access is open and
//   aborts it after MEM_TIMEOUT wait cycles. Resolves branch/jump redirection
//   and owns the MEM/WB register.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   RegWriteM..ZeroM         EX/MEM control bits and ALU zero flag
//   ALUResultM, ReadData2_M  address / ALU result, store data
//   WriteAddr_M, PCTargetM   destination register, branch/jump target
//   dmem_req/we/addr/wdata   data-memory request channel
//   dmem_ready, dmem_rdata   data-memory completion and load data
//   stall_mem                freezes PC, IF/ID, ID/EX and EX/MEM
//   PCSrcM, PCTargetOut      fetch redirection
//   RegWriteW..WriteAddr_W   MEM/WB register outputs
//   mem_err                  one-cycle pulse after a timeout abort

module memory_stage #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic        MemtoRegM,
    input  logic        BranchM,
    input  logic        BNEM,
    input  logic        JMPM,
    input  logic        ZeroM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] ReadData2_M,
    input  logic [4:0]  WriteAddr_M,
    input  logic [31:0] PCTargetM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall_mem,
    output logic        PCSrcM,
    output logic [31:0] PCTargetOut,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUResultW,
    output logic [4:0]  WriteAddr_W,
    output logic        mem_err
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [7:0] TIMEOUT = MEM_TIMEOUT[7:0];

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        access;
    logic        is_load;
    logic        abort;

    logic        reg_write_q, mem_to_reg_q, mem_err_q;
    logic [31:0] read_data_q, alu_result_q;
    logic [4:0]  write_addr_q;

    assign access  = MemReadM | MemWriteM;
    // A simultaneous read+write is treated as a store: no load data captured.
    assign is_load = MemReadM & ~MemWriteM;

    assign dmem_we    = MemWriteM;
    assign dmem_addr  = ALUResultM;
    assign dmem_wdata = ReadData2_M;

    assign PCSrcM      = JMPM | (BranchM & ZeroM) | (BNEM & ~ZeroM);
    assign PCTargetOut = PCTargetM;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dmem_req = 1'b0;
        abort    = 1'b0;
        case (state_q)
            S_IDLE: begin
                dmem_req = access;
                if (access && !dmem_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = 8'd1;
                end
            end
            S_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == TIMEOUT) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Low in both the completion cycle and the abort cycle so upstream
    // advances exactly when the MEM/WB register takes its final value.
    assign stall_mem = dmem_req & ~dmem_ready & ~abort;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            read_data_q  <= 32'h0;
            alu_result_q <= 32'h0;
            write_addr_q <= 5'd0;
            mem_err_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= abort;
            if (abort) begin
                reg_write_q  <= 1'b0;
                mem_to_reg_q <= 1'b0;
                read_data_q  <= 32'h0;
            end else if (stall_mem) begin
                // Bubble; data fields hold since nothing consumes them.
                reg_write_q  <= 1'b0;
                mem_to_reg_q <= 1'b0;
            end else begin
                reg_write_q  <= RegWriteM;
                mem_to_reg_q <= MemtoRegM;
                alu_result_q <= ALUResultM;
                write_addr_q <= WriteAddr_M;
                read_data_q  <= is_load ? dmem_rdata : 32'h0;
            end
        end
    end

    assign RegWriteW   = reg_write_q;
    assign MemtoRegW   = mem_to_reg_q;
    assign ReadDataW   = read_data_q;
    assign ALUResultW  = alu_result_q;
    assign WriteAddr_W = write_addr_q;
    assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed self-checking bench for memory_stage

module tb_memory_stage;

    logic        clk;
    logic        rst;
    logic        RegWriteM, MemReadM, MemWriteM, MemtoRegM;
    logic        BranchM, BNEM, JMPM, ZeroM;
    logic [31:0] ALUResultM, ReadData2_M, PCTargetM;
    logic [4:0]  WriteAddr_M;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall_mem, PCSrcM;
    logic [31:0] PCTargetOut;
    logic        RegWriteW, MemtoRegW, mem_err;
    logic [31:0] ReadDataW, ALUResultW;
    logic [4:0]  WriteAddr_W;

    int vectors;
    int miscompares;

    memory_stage #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .MemtoRegM(MemtoRegM), .BranchM(BranchM), .BNEM(BNEM), .JMPM(JMPM),
        .ZeroM(ZeroM), .ALUResultM(ALUResultM), .ReadData2_M(ReadData2_M),
        .WriteAddr_M(WriteAddr_M), .PCTargetM(PCTargetM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .stall_mem(stall_mem), .PCSrcM(PCSrcM), .PCTargetOut(PCTargetOut),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW),
        .ALUResultW(ALUResultW), .WriteAddr_W(WriteAddr_W), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RegWriteM = 0; MemReadM = 0; MemWriteM = 0; MemtoRegM = 0;
        BranchM = 0; BNEM = 0; JMPM = 0; ZeroM = 0;
        ALUResultM = 0; ReadData2_M = 0; WriteAddr_M = 0; PCTargetM = 0;
        dmem_ready = 0; dmem_rdata = 0;
    endtask

    task automatic set_load(input logic [31:0] addr, input logic [4:0] rd,
                            input logic rdy, input logic [31:0] rdata);
        clear_inputs();
        MemReadM = 1; MemtoRegM = 1; RegWriteM = 1;
        ALUResultM = addr; WriteAddr_M = rd;
        dmem_ready = rdy; dmem_rdata = rdata;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        clear_inputs();
        rst = 0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            {RegWriteM, MemReadM, MemWriteM, MemtoRegM} = 4'($urandom);
            ALUResultM = $urandom; ReadData2_M = $urandom; WriteAddr_M = 5'($urandom);
            dmem_ready = 1'($urandom); dmem_rdata = $urandom;
            tick();
            chk("rst_regwrite", {31'd0, RegWriteW}, 32'd0);
            chk("rst_memtoreg", {31'd0, MemtoRegW}, 32'd0);
            chk("rst_readdata", ReadDataW, 32'd0);
            chk("rst_aluresult", ALUResultW, 32'd0);
            chk("rst_writeaddr", {27'd0, WriteAddr_W}, 32'd0);
            chk("rst_memerr", {31'd0, mem_err}, 32'd0);
            chk("rst_idle_req", {31'd0, dmem_req}, {31'd0, MemReadM | MemWriteM});
        end
        clear_inputs();
        rst = 1;
        tick();
        chk("post_rst_bubble", {31'd0, RegWriteW}, 32'd0);
        chk("post_rst_req", {31'd0, dmem_req}, 32'd0);

        // Zero-wait load
        set_load(32'h100, 5'd5, 1'b1, 32'hDEADBEEF);
        #1;
        chk("zw_req", {31'd0, dmem_req}, 32'd1);
        chk("zw_we", {31'd0, dmem_we}, 32'd0);
        chk("zw_stall", {31'd0, stall_mem}, 32'd0);
        chk("zw_addr", dmem_addr, 32'h100);
        tick();
        chk("zw_rdata", ReadDataW, 32'hDEADBEEF);
        chk("zw_waddr", {27'd0, WriteAddr_W}, 32'd5);
        chk("zw_regwrite", {31'd0, RegWriteW}, 32'd1);
        chk("zw_memtoreg", {31'd0, MemtoRegW}, 32'd1);
        chk("zw_alures", ALUResultW, 32'h100);

        // 3-wait store, back-to-back with the load
        clear_inputs();
        MemWriteM = 1; ALUResultM = 32'h200; ReadData2_M = 32'h12345678; WriteAddr_M = 5'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_stall", {31'd0, stall_mem}, 32'd1);
            chk("st_req", {31'd0, dmem_req}, 32'd1);
            chk("st_we", {31'd0, dmem_we}, 32'd1);
            chk("st_wdata", dmem_wdata, 32'h12345678);
            tick();
            chk("st_bubble", {31'd0, RegWriteW}, 32'd0);
            chk("st_bubble_m2r", {31'd0, MemtoRegW}, 32'd0);
        end
        dmem_ready = 1;
        #1;
        chk("st_done_stall", {31'd0, stall_mem}, 32'd0);
        chk("st_done_req", {31'd0, dmem_req}, 32'd1);
        tick();
        chk("st_regwrite", {31'd0, RegWriteW}, 32'd0);
        chk("st_alures", ALUResultW, 32'h200);
        chk("st_rdata", ReadDataW, 32'h0);
        chk("st_waddr", {27'd0, WriteAddr_W}, 32'd3);

        // Timeout (MEM_TIMEOUT=4): 5 request cycles, stall for 4
        set_load(32'h300, 5'd7, 1'b0, 32'h0);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("to_req", {31'd0, dmem_req}, 32'd1);
            chk("to_stall", {31'd0, stall_mem}, (c < 4) ? 32'd1 : 32'd0);
            chk("to_noerr", {31'd0, mem_err}, 32'd0);
            tick();
        end
        chk("to_memerr", {31'd0, mem_err}, 32'd1);
        chk("to_regwrite", {31'd0, RegWriteW}, 32'd0);
        chk("to_rdata", ReadDataW, 32'h0);
        set_load(32'h304, 5'd8, 1'b1, 32'hCAFEF00D);
        #1;
        chk("after_to_stall", {31'd0, stall_mem}, 32'd0);
        tick();
        chk("after_to_err_pulse", {31'd0, mem_err}, 32'd0);
        chk("after_to_regwrite", {31'd0, RegWriteW}, 32'd1);
        chk("after_to_rdata", ReadDataW, 32'hCAFEF00D);
        chk("after_to_waddr", {27'd0, WriteAddr_W}, 32'd8);

        // Ready arriving in the would-be abort cycle completes the access
        set_load(32'h308, 5'd9, 1'b0, 32'h0BADF00D);
        for (int c = 0; c < 4; c++) tick();
        dmem_ready = 1;
        #1;
        chk("late_stall", {31'd0, stall_mem}, 32'd0);
        chk("late_req", {31'd0, dmem_req}, 32'd1);
        tick();
        chk("late_noerr", {31'd0, mem_err}, 32'd0);
        chk("late_regwrite", {31'd0, RegWriteW}, 32'd1);
        chk("late_rdata", ReadDataW, 32'h0BADF00D);

        // Branches and jump: no access, no stall
        clear_inputs();
        BNEM = 1; ZeroM = 0; PCTargetM = 32'h400;
        #1;
        chk("bne_pcsrc", {31'd0, PCSrcM}, 32'd1);
        chk("bne_target", PCTargetOut, 32'h400);
        chk("bne_stall", {31'd0, stall_mem}, 32'd0);
        chk("bne_req", {31'd0, dmem_req}, 32'd0);
        clear_inputs();
        BranchM = 1; ZeroM = 0; PCTargetM = 32'h500;
        #1;
        chk("beq_nt_pcsrc", {31'd0, PCSrcM}, 32'd0);
        ZeroM = 1;
        #1;
        chk("beq_t_pcsrc", {31'd0, PCSrcM}, 32'd1);
        clear_inputs();
        BNEM = 1; ZeroM = 1;
        #1;
        chk("bne_nt_pcsrc", {31'd0, PCSrcM}, 32'd0);
        clear_inputs();
        JMPM = 1; PCTargetM = 32'h600;
        #1;
        chk("jmp_pcsrc", {31'd0, PCSrcM}, 32'd1);
        chk("jmp_target", PCTargetOut, 32'h600);

        // Non-memory ALU instruction, 1-cycle latency
        clear_inputs();
        RegWriteM = 1; ALUResultM = 32'h55; WriteAddr_M = 5'd9;
        #1;
        chk("alu_stall", {31'd0, stall_mem}, 32'd0);
        tick();
        chk("alu_regwrite", {31'd0, RegWriteW}, 32'd1);
        chk("alu_alures", ALUResultW, 32'h55);
        chk("alu_rdata", ReadDataW, 32'h0);
        chk("alu_memtoreg", {31'd0, MemtoRegW}, 32'd0);

        // Reset during WAIT drops the request silently
        set_load(32'h700, 5'd10, 1'b0, 32'h0);
        for (int c = 0; c < 3; c++) tick();
        #1;
        chk("rw_stall", {31'd0, stall_mem}, 32'd1);
        clear_inputs();
        rst = 0;
        tick();
        chk("rw_req", {31'd0, dmem_req}, 32'd0);
        chk("rw_memerr", {31'd0, mem_err}, 32'd0);
        chk("rw_regwrite", {31'd0, RegWriteW}, 32'd0);
        chk("rw_alures", ALUResultW, 32'd0);
        chk("rw_waddr", {27'd0, WriteAddr_W}, 32'd0);
        rst = 1;
        tick();
        chk("rw_post_memerr", {31'd0, mem_err}, 32'd0);
        chk("rw_post_req", {31'd0, dmem_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
